// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and write-port arbitration for the register file
package regfile_pkg;

    localparam int RF_XLEN      = 32;
    localparam int RF_NREGS     = 32;
    localparam int RF_AW        = $clog2(RF_NREGS);
    localparam int RF_MAX_PORTS = 32;
    localparam int RF_PORT_W    = $clog2(RF_MAX_PORTS);

    typedef logic [RF_AW-1:0]     rf_idx_t;
    typedef logic [RF_XLEN-1:0]   rf_word_t;
    typedef logic [RF_PORT_W-1:0] rf_port_t;

    localparam rf_idx_t RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic     hit;
        rf_port_t port;
    } rf_win_t;

    // Highest-index matching write port wins; used by both storage and bypass.
    function automatic rf_win_t rf_win(input logic [RF_MAX_PORTS-1:0] match);
        rf_win_t w;
        w = '0;
        for (int j = 0; j < RF_MAX_PORTS; j++) begin
            if (match[j]) begin
                w.hit  = 1'b1;
                w.port = rf_port_t'(j);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write, alloc and flush bundle between the pipeline and the register file
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with flush, write-clear and alloc-set priority
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_ADDR);

    logic [NREGS-1:0] busy_nxt;

    // Later statements override earlier ones: flush, then write-clear, then alloc.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != ZERO_ADDR) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with r0 hardwired to zero, optional bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_ADDR);

    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] busy_vec;

    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];
    logic [AW-1:0]   ra [NRD];

    logic [NREGS-1:0] reg_hit;
    logic [XLEN-1:0]  reg_val [NREGS];

    logic [NRD*XLEN-1:0] rd_d;
    logic [NRD-1:0]      rd_b;

    function automatic logic [XLEN-1:0] port_data(input rf_port_t p);
        logic [XLEN-1:0] v;
        v = '0;
        for (int j = 0; j < NWR; j++) begin
            if (p == rf_port_t'(j)) begin
                v = wd[j];
            end
        end
        return v;
    endfunction

    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wa[j] = bus.wr_addr[j*AW +: AW];
            wd[j] = bus.wr_data[j*XLEN +: XLEN];
        end
        for (int i = 0; i < NRD; i++) begin
            ra[i] = bus.rd_addr[i*AW +: AW];
        end
    end

    always_comb begin
        logic [RF_MAX_PORTS-1:0] match;
        rf_win_t                 win;
        match = '0;
        win   = '0;
        for (int r = 0; r < NREGS; r++) begin
            match = '0;
            for (int j = 0; j < NWR; j++) begin
                match[j] = bus.wr_en[j] && (wa[j] == AW'(r)) && (AW'(r) != ZERO_ADDR);
            end
            win        = rf_win(match);
            reg_hit[r] = win.hit;
            reg_val[r] = port_data(win.port);
        end
    end

    // mem[0] is never written, so it stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (reg_hit[r]) begin
                    mem[r] <= reg_val[r];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .busy       (busy_vec)
    );

    // Bypass is gated by reset too, so a pending write cannot leak out while rst_n is low.
    always_comb begin
        logic [RF_MAX_PORTS-1:0] match;
        rf_win_t                 win;
        rd_d  = '0;
        rd_b  = '0;
        match = '0;
        win   = '0;
        for (int i = 0; i < NRD; i++) begin
            match = '0;
            for (int j = 0; j < NWR; j++) begin
                match[j] = bus.wr_en[j] && (wa[j] == ra[i]);
            end
            win = rf_win(match);
            if (rst_n && ra[i] != ZERO_ADDR) begin
                if (BYPASS != 0 && win.hit) begin
                    rd_d[i*XLEN +: XLEN] = port_data(win.port);
                    rd_b[i]              = 1'b0;
                end else begin
                    rd_d[i*XLEN +: XLEN] = mem[ra[i]];
                    rd_b[i]              = busy_vec[ra[i]];
                end
            end
        end
    end

    assign bus.rd_data = rd_d;
    assign bus.rd_busy = rd_b;

endmodule
